// File: rtl/oled_frame_scheduler.sv
// oled_frame_scheduler
//   Owns the shared SPI byte serializer of an SSD1306 128x64 OLED. After reset
//   it pulses the panel reset line, sends the power-up command list, and then
//   arbitrates between single host command bytes and full-frame refreshes read
//   from a synchronous-read framebuffer RAM.
//
//   Build option: define OLED_AUTO_REFRESH_EN to add a free-running timer that
//   raises a refresh request every REFRESH_PERIOD cycles once init is done.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   o_lcd_rst           panel reset (active low)
//   o_tx_valid/byte/dc  byte offered to the serializer (dc: 0 cmd, 1 data)
//   i_tx_ready          serializer accepts when valid & ready
//   o_fb_addr/i_fb_data framebuffer read port (data one cycle after address)
//   i_cmd_valid/byte    host command byte request
//   o_cmd_ready         host byte taken this cycle
//   i_refresh_req       single-cycle refresh request
//   o_busy              low only while idle
//   o_frame_done        one-cycle pulse after the last frame byte transfers
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RST_LOW  | panel reset driven low for RESET_CYCLES
// RST_HIGH | panel reset released, wait RESET_CYCLES
// INIT     | send the 23-byte power-up command list
// IDLE     | arbitrate host byte vs pending refresh
// HOST     | one host command byte in flight
// WIN      | send the 6-byte column/page window commands
// FETCH    | framebuffer address presented
// LOAD     | framebuffer data captured into the output byte
// SEND     | data byte in flight, advance or finish the frame
module oled_frame_scheduler #(
  parameter int RESET_CYCLES   = 1000,
  parameter int FB_DEPTH       = 1024,
  parameter int FB_ADDR_W      = 10,
  parameter int REFRESH_PERIOD = 1000000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  output logic                 o_lcd_rst,
  output logic                 o_tx_valid,
  output logic [7:0]           o_tx_byte,
  output logic                 o_tx_dc,
  input  logic                 i_tx_ready,
  output logic [FB_ADDR_W-1:0] o_fb_addr,
  input  logic [7:0]           i_fb_data,
  input  logic                 i_cmd_valid,
  input  logic [7:0]           i_cmd_byte,
  output logic                 o_cmd_ready,
  input  logic                 i_refresh_req,
  output logic                 o_busy,
  output logic                 o_frame_done
);

  localparam int CNT_W = $clog2(RESET_CYCLES + 1);
  localparam logic [4:0] INIT_LAST = 5'd22;
  localparam logic [4:0] WIN_LAST  = 5'd5;
  localparam logic [FB_ADDR_W-1:0] ADDR_LAST = FB_ADDR_W'(FB_DEPTH - 1);

  typedef enum logic [3:0] {
    S_RST_LOW, S_RST_HIGH, S_INIT, S_IDLE, S_HOST, S_WIN, S_FETCH, S_LOAD, S_SEND
  } state_t;

  function automatic logic [7:0] init_byte(input logic [4:0] i);
    case (i)
      5'd0:  init_byte = 8'hAE;  5'd1:  init_byte = 8'h81;  5'd2:  init_byte = 8'h7F;
      5'd3:  init_byte = 8'hA6;  5'd4:  init_byte = 8'h20;  5'd5:  init_byte = 8'h00;
      5'd6:  init_byte = 8'hC8;  5'd7:  init_byte = 8'h40;  5'd8:  init_byte = 8'hA1;
      5'd9:  init_byte = 8'hA8;  5'd10: init_byte = 8'h3F;  5'd11: init_byte = 8'hD3;
      5'd12: init_byte = 8'h00;  5'd13: init_byte = 8'hD5;  5'd14: init_byte = 8'h80;
      5'd15: init_byte = 8'hD9;  5'd16: init_byte = 8'h22;  5'd17: init_byte = 8'hDB;
      5'd18: init_byte = 8'h20;  5'd19: init_byte = 8'h8D;  5'd20: init_byte = 8'h14;
      5'd21: init_byte = 8'hA4;  5'd22: init_byte = 8'hAF;
      default: init_byte = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] win_byte(input logic [4:0] i);
    case (i)
      5'd0: win_byte = 8'h21;  5'd1: win_byte = 8'h00;  5'd2: win_byte = 8'h7F;
      5'd3: win_byte = 8'h22;  5'd4: win_byte = 8'h00;  5'd5: win_byte = 8'h07;
      default: win_byte = 8'h00;
    endcase
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [4:0]           idx_q, idx_d;
  logic [FB_ADDR_W-1:0] addr_q, addr_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 tx_dc_q, tx_dc_d;
  logic                 lcd_rst_q, lcd_rst_d;
  logic                 frame_done_q, frame_done_d;
  logic                 pend_q, pend_d;
  logic                 last_host_q, last_host_d;

  logic xfer;
  logic tick;
  logic ref_pend;

  assign xfer = tx_valid_q & i_tx_ready;

`ifdef OLED_AUTO_REFRESH_EN
  localparam int TMR_W = $clog2(REFRESH_PERIOD + 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             tmr_run_q, tmr_run_d;
  logic             init_done;

  assign init_done = (state_q == S_INIT) && xfer && (idx_q == INIT_LAST);

  always_comb begin
    tmr_d     = tmr_q;
    tmr_run_d = tmr_run_q;
    tick      = 1'b0;
    if (tmr_run_q) begin
      if (tmr_q == '0) begin
        tick  = 1'b1;
        tmr_d = TMR_W'(REFRESH_PERIOD - 1);
      end else begin
        tmr_d = tmr_q - TMR_W'(1);
      end
    end else if (init_done) begin
      tmr_run_d = 1'b1;
      tmr_d     = TMR_W'(REFRESH_PERIOD - 1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmr_q     <= '0;
      tmr_run_q <= 1'b0;
    end else begin
      tmr_q     <= tmr_d;
      tmr_run_q <= tmr_run_d;
    end
  end
`else
  assign tick = 1'b0;
`endif

  // A request arriving in the same cycle as the arbitration counts as pending,
  // so a simultaneous host byte and refresh pulse are arbitrated fairly.
  assign ref_pend = pend_q | i_refresh_req | tick;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    tx_valid_d   = tx_valid_q;
    tx_byte_d    = tx_byte_q;
    tx_dc_d      = tx_dc_q;
    lcd_rst_d    = lcd_rst_q;
    frame_done_d = 1'b0;
    pend_d       = ref_pend;
    last_host_d  = last_host_q;

    case (state_q)
      S_RST_LOW: begin
        if (cnt_q == '0) begin
          cnt_d     = CNT_W'(RESET_CYCLES - 1);
          lcd_rst_d = 1'b1;
          state_d   = S_RST_HIGH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RST_HIGH: begin
        if (cnt_q == '0) begin
          idx_d      = '0;
          tx_byte_d  = init_byte(5'd0);
          tx_dc_d    = 1'b0;
          tx_valid_d = 1'b1;
          state_d    = S_INIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_INIT: begin
        if (xfer) begin
          if (idx_q == INIT_LAST) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            idx_d     = idx_q + 5'd1;
            tx_byte_d = init_byte(idx_q + 5'd1);
          end
        end
      end
      S_IDLE: begin
        // last_host only moves on contested grants; an uncontested grant
        // leaves the round-robin pointer where it was.
        if (i_cmd_valid && !(ref_pend && last_host_q)) begin
          if (ref_pend) last_host_d = 1'b1;
          tx_byte_d  = i_cmd_byte;
          tx_dc_d    = 1'b0;
          tx_valid_d = 1'b1;
          state_d    = S_HOST;
        end else if (ref_pend) begin
          if (i_cmd_valid) last_host_d = 1'b0;
          pend_d     = 1'b0;
          idx_d      = '0;
          tx_byte_d  = win_byte(5'd0);
          tx_dc_d    = 1'b0;
          tx_valid_d = 1'b1;
          state_d    = S_WIN;
        end
      end
      S_HOST: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_WIN: begin
        if (xfer) begin
          if (idx_q == WIN_LAST) begin
            tx_valid_d = 1'b0;
            addr_d     = '0;
            state_d    = S_FETCH;
          end else begin
            idx_d     = idx_q + 5'd1;
            tx_byte_d = win_byte(idx_q + 5'd1);
          end
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        tx_byte_d  = i_fb_data;
        tx_dc_d    = 1'b1;
        tx_valid_d = 1'b1;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          if (addr_q == ADDR_LAST) begin
            frame_done_d = 1'b1;
            addr_d       = '0;
            state_d      = S_IDLE;
          end else begin
            addr_d  = addr_q + FB_ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_RST_LOW;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_RST_LOW;
      cnt_q        <= CNT_W'(RESET_CYCLES - 1);
      idx_q        <= '0;
      addr_q       <= '0;
      tx_valid_q   <= 1'b0;
      tx_byte_q    <= 8'h00;
      tx_dc_q      <= 1'b0;
      lcd_rst_q    <= 1'b0;
      frame_done_q <= 1'b0;
      pend_q       <= 1'b0;
      last_host_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      tx_valid_q   <= tx_valid_d;
      tx_byte_q    <= tx_byte_d;
      tx_dc_q      <= tx_dc_d;
      lcd_rst_q    <= lcd_rst_d;
      frame_done_q <= frame_done_d;
      pend_q       <= pend_d;
      last_host_q  <= last_host_d;
    end
  end

  assign o_lcd_rst    = lcd_rst_q;
  assign o_tx_valid   = tx_valid_q;
  assign o_tx_byte    = tx_byte_q;
  assign o_tx_dc      = tx_dc_q;
  assign o_fb_addr    = addr_q;
  assign o_frame_done = frame_done_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_cmd_ready  = (state_q == S_HOST) && xfer;

endmodule

// File: tb/tb_oled_frame_scheduler.sv
module tb_oled_frame_scheduler;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic       o_lcd_rst, o_tx_valid, o_tx_dc, o_cmd_ready, o_busy, o_frame_done;
  logic [7:0] o_tx_byte;
  logic       i_tx_ready = 1'b1;
  logic [9:0] o_fb_addr;
  logic [7:0] i_fb_data;
  logic       i_cmd_valid = 1'b0;
  logic [7:0] i_cmd_byte = 8'h00;
  logic       i_refresh_req = 1'b0;

  always #5 i_clk = ~i_clk;

  oled_frame_scheduler dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .o_lcd_rst(o_lcd_rst),
    .o_tx_valid(o_tx_valid), .o_tx_byte(o_tx_byte), .o_tx_dc(o_tx_dc),
    .i_tx_ready(i_tx_ready), .o_fb_addr(o_fb_addr), .i_fb_data(i_fb_data),
    .i_cmd_valid(i_cmd_valid), .i_cmd_byte(i_cmd_byte), .o_cmd_ready(o_cmd_ready),
    .i_refresh_req(i_refresh_req), .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  // framebuffer RAM, synchronous read
  logic [7:0] fb [0:1023];
  logic [7:0] fb_rd;
  always @(posedge i_clk) fb_rd <= fb[o_fb_addr];
  assign i_fb_data = fb_rd;

  logic [7:0] init_seq [23] = '{8'hAE, 8'h81, 8'h7F, 8'hA6, 8'h20, 8'h00, 8'hC8, 8'h40,
                                8'hA1, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'hD5, 8'h80, 8'hD9,
                                8'h22, 8'hDB, 8'h20, 8'h8D, 8'h14, 8'hA4, 8'hAF};
  logic [7:0] win_seq [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

  typedef struct packed {
    logic [7:0] b;
    logic       dc;
    logic       host;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   model_last_host = 1'b1;
  bit   rdy_rand = 1'b0;
  bit   stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // ---------------- reference model: transaction-level expectations --------
  task automatic push_init();
    foreach (init_seq[i]) sb.push_back('{b: init_seq[i], dc: 1'b0, host: 1'b0, last: 1'b0});
  endtask

  task automatic push_frame();
    foreach (win_seq[i]) sb.push_back('{b: win_seq[i], dc: 1'b0, host: 1'b0, last: 1'b0});
    for (int i = 0; i < 1024; i++)
      sb.push_back('{b: fb[i], dc: 1'b1, host: 1'b0, last: (i == 1023)});
  endtask

  task automatic push_host(input logic [7:0] b);
    sb.push_back('{b: b, dc: 1'b0, host: 1'b1, last: 1'b0});
  endtask

  task automatic randomize_fb();
    for (int i = 0; i < 1024; i++) fb[i] = 8'($urandom);
  endtask

  // ---------------- serializer ready driver ---------------------------------
  always @(posedge i_clk) begin
    #1;
    i_tx_ready = stall ? 1'b0 : (rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  // ---------------- monitor / scoreboard ------------------------------------
  bit         exp_fd = 1'b0;
  bit         stall_chk = 1'b0;
  logic [7:0] st_b;
  logic       st_dc;
  exp_t       mon_e;

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      exp_fd    = 1'b0;
      stall_chk = 1'b0;
    end else begin
      check("frame_done", o_frame_done, exp_fd);
      exp_fd = 1'b0;
      if (stall_chk) begin
        check("stall_valid", o_tx_valid, 1'b1);
        check("stall_byte", o_tx_byte, st_b);
        check("stall_dc", o_tx_dc, st_dc);
      end
      stall_chk = 1'b0;
      if (o_tx_valid && i_tx_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_byte: got %02h dc=%0d want none", o_tx_byte, o_tx_dc);
        end else begin
          mon_e = sb.pop_front();
          check("tx_byte", o_tx_byte, mon_e.b);
          check("tx_dc", o_tx_dc, mon_e.dc);
          check("cmd_ready_xfer", o_cmd_ready, mon_e.host);
          exp_fd = mon_e.last;
        end
      end else begin
        check("cmd_ready_idle", o_cmd_ready, 1'b0);
        if (o_tx_valid) begin
          stall_chk = 1'b1;
          st_b      = o_tx_byte;
          st_dc     = o_tx_dc;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic pulse_req();
    step();
    i_refresh_req = 1'b1;
    step();
    i_refresh_req = 1'b0;
  endtask

  task automatic host_send(input logic [7:0] b);
    int k = 0;
    step();
    i_cmd_valid = 1'b1;
    i_cmd_byte  = b;
    do begin
      @(negedge i_clk);
      k++;
    end while (!o_cmd_ready && k < 20000);
    if (!o_cmd_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL host_accept_timeout: got no cmd_ready want cmd_ready within 20000");
    end
    step();
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    do begin
      @(negedge i_clk);
      k++;
    end while (!(sb.size() == 0 && !o_busy) && k < 20000);
    check({name, "_idle"}, {sb.size() == 0, o_busy}, 2'b10);
    sb.delete();
  endtask

  // Simultaneous host byte and refresh pulse; the model grants the side not
  // granted at the previous contested decision.
  task automatic pair(input logic [7:0] b);
    if (model_last_host) begin
      push_frame();
      push_host(b);
    end else begin
      push_host(b);
      push_frame();
    end
    model_last_host = !model_last_host;
    fork
      host_send(b);
      pulse_req();
    join
  endtask

  task automatic power_up_timing();
    int lo = 0;
    int hi = 0;
    forever begin
      @(negedge i_clk);
      if (o_lcd_rst || lo >= 5000) break;
      lo++;
    end
    check("lcd_low_cycles", lo, 1000);
    while (!o_tx_valid && hi < 5000) begin
      if (!o_lcd_rst) break;
      hi++;
      @(negedge i_clk);
    end
    check("lcd_high_cycles", hi, 1000);
    check("lcd_high_at_init", o_lcd_rst, 1'b1);
  endtask

  // ---------------- main sequence -------------------------------------------
  initial begin
    for (int i = 0; i < 1024; i++) fb[i] = 8'(i);
    #2 i_rst_n = 1'b0;
    #20;
    check("rst_lcd_rst", o_lcd_rst, 1'b0);
    check("rst_tx_valid", o_tx_valid, 1'b0);
    check("rst_tx_byte", o_tx_byte, 8'h00);
    check("rst_tx_dc", o_tx_dc, 1'b0);
    check("rst_cmd_ready", o_cmd_ready, 1'b0);
    check("rst_fb_addr", o_fb_addr, 10'd0);
    check("rst_frame_done", o_frame_done, 1'b0);
    check("rst_busy", o_busy, 1'b1);

    step();
    push_init();
    i_rst_n = 1'b1;
    power_up_timing();
    wait_idle("init");

    // incrementing frame with a 20-cycle serializer stall in the middle
    push_frame();
    pulse_req();
    repeat (300) step();
    stall = 1'b1;
    repeat (20) step();
    stall = 1'b0;
    wait_idle("frame_inc");

    // contested grants: reset pointer says host last -> frame first, then host
    pair(8'hA6);
    wait_idle("pair_frame_first");
    randomize_fb();
    pair(8'($urandom));
    wait_idle("pair_host_first");

    // two requests during one frame merge into exactly one follow-up frame
    randomize_fb();
    push_frame();
    push_frame();
    pulse_req();
    repeat (100) step();
    pulse_req();
    repeat (500) step();
    pulse_req();
    wait_idle("double_req");
    repeat (50) step();
    check("no_extra_frame", {sb.size() == 0, o_busy, o_tx_valid}, 3'b100);

    // randomized mix with a jittery serializer
    rdy_rand = 1'b1;
    for (int it = 0; it < 5; it++) begin
      int op = $urandom_range(0, 2);
      logic [7:0] hb = 8'($urandom);
      if (op == 0) begin
        push_host(hb);
        host_send(hb);
      end else if (op == 1) begin
        randomize_fb();
        push_frame();
        pulse_req();
      end else begin
        randomize_fb();
        pair(hb);
      end
      wait_idle("rand_op");
    end
    rdy_rand = 1'b0;

    // reset mid-frame: abort at once, full power-up repeats
    push_frame();
    pulse_req();
    repeat (400) step();
    i_rst_n = 1'b0;
    #1;
    check("midrst_tx_valid", o_tx_valid, 1'b0);
    check("midrst_lcd_rst", o_lcd_rst, 1'b0);
    check("midrst_busy", o_busy, 1'b1);
    sb.delete();
    model_last_host = 1'b1;
    repeat (5) step();
    push_init();
    i_rst_n = 1'b1;
    power_up_timing();
    // request issued during init is held until init completes
    randomize_fb();
    push_frame();
    pulse_req();
    wait_idle("reinit_held_req");

    pair(8'h5C);
    wait_idle("pair_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
